line_mem_arbiter: RTL and testbench

- Shares the single cacheline-granular backing-memory port (dfp-style: addr/read/write/256-bit wdata/rdata/resp) between the instruction cache and the data cache.
- Grants one requester at a time using round-robin ordering.
- Latches the winner's command and holds it on the memory port until the response arrives, then routes the response back to that requester only.
- Sits between the two cache miss/writeback paths and the burst/DRAM adapter.

---
 rtl/line_mem_arbiter.sv | 125 ++++++++++++
 tb/tb_line_mem_arbiter.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/line_mem_arbiter.sv
// Round-robin arbiter that shares one cacheline-wide memory port between the icache and dcache.
// The winner's command is held on the memory port until mem_resp, then the response is routed back to that cache.
module line_mem_arbiter #(
  parameter int ADDR_W   = 32,
  parameter int LINE_W   = 256,
  parameter int OFFSET_W = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic              i_read,
  output logic [LINE_W-1:0] i_rdata,
  output logic              i_resp,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic              d_read,
  input  logic              d_write,
  input  logic [LINE_W-1:0] d_wdata,
  output logic [LINE_W-1:0] d_rdata,
  output logic              d_resp,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_read,
  output logic              mem_write,
  output logic [LINE_W-1:0] mem_wdata,
  input  logic [LINE_W-1:0] mem_rdata,
  input  logic              mem_resp,
  output logic              proto_err
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    HOLD = 2'd2
  } state_t;

  localparam logic OWN_I = 1'b0;
  localparam logic OWN_D = 1'b1;
  localparam logic [ADDR_W-1:0] ALIGN_MASK = {{(ADDR_W-OFFSET_W){1'b1}}, {OFFSET_W{1'b0}}};

  state_t r_state;
  state_t w_next;

  logic              r_rrLast;
  logic              r_owner;
  logic              r_memRead;
  logic              r_memWrite;
  logic              r_protoErr;
  logic [ADDR_W-1:0] r_addr;
  logic [LINE_W-1:0] r_wdata;

  logic w_iReq;
  logic w_dReq;
  logic w_grant;
  logic w_grantD;
  logic w_grantWrite;
  logic w_done;
  logic w_iResp;
  logic w_dResp;

  assign w_iReq       = i_read;
  assign w_dReq       = d_read | d_write;
  assign w_grant      = (r_state == IDLE) && (w_iReq || w_dReq);
  // On a tie the requester that was not served last wins.
  assign w_grantD     = w_dReq && (!w_iReq || (r_rrLast == OWN_I));
  assign w_grantWrite = w_grantD && d_write;
  assign w_done       = (r_state == BUSY) && mem_resp;
  assign w_iResp      = w_done && (r_owner == OWN_I);
  assign w_dResp      = w_done && (r_owner == OWN_D);

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (w_iReq || w_dReq) w_next = BUSY;
      BUSY:    if (mem_resp) w_next = HOLD;
      HOLD:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rrLast   <= OWN_I;
      r_owner    <= OWN_I;
      r_memRead  <= 1'b0;
      r_memWrite <= 1'b0;
      r_addr     <= '0;
      r_wdata    <= '0;
    end else if (w_grant) begin
      r_owner    <= w_grantD;
      r_addr     <= (w_grantD ? d_addr : i_addr) & ALIGN_MASK;
      r_memWrite <= w_grantWrite;
      r_memRead  <= !w_grantWrite;
      r_wdata    <= w_grantWrite ? d_wdata : '0;
    end else if (w_done) begin
      r_memRead  <= 1'b0;
      r_memWrite <= 1'b0;
      r_rrLast   <= r_owner;
    end
  end

  // Sticky: stray responses outside BUSY, or a dcache read+write collision at grant time.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_protoErr <= 1'b0;
    end else if ((mem_resp && (r_state != BUSY)) ||
                 ((r_state == IDLE) && d_read && d_write)) begin
      r_protoErr <= 1'b1;
    end
  end

  assign mem_addr  = r_addr;
  assign mem_read  = r_memRead;
  assign mem_write = r_memWrite;
  assign mem_wdata = r_wdata;
  assign i_resp    = w_iResp;
  assign d_resp    = w_dResp;
  assign i_rdata   = w_iResp ? mem_rdata : '0;
  assign d_rdata   = w_dResp ? mem_rdata : '0;
  assign proto_err = r_protoErr;

endmodule

// File: tb/tb_line_mem_arbiter.sv
// Directed bench for line_mem_arbiter: a behavioural memory answers each strobe and a
// scoreboard queue holds the response each cache is expected to see.
module tb_line_mem_arbiter;

  localparam logic OWN_I = 1'b0;
  localparam logic OWN_D = 1'b1;

  typedef struct packed {
    logic         owner;
    logic [255:0] data;
  } resp_t;

  logic         clk;
  logic         rst;
  logic [31:0]  i_addr;
  logic         i_read;
  logic [255:0] i_rdata;
  logic         i_resp;
  logic [31:0]  d_addr;
  logic         d_read;
  logic         d_write;
  logic [255:0] d_wdata;
  logic [255:0] d_rdata;
  logic         d_resp;
  logic [31:0]  mem_addr;
  logic         mem_read;
  logic         mem_write;
  logic [255:0] mem_wdata;
  logic [255:0] mem_rdata;
  logic         mem_resp;
  logic         proto_err;

  int    total;
  int    bad;
  resp_t sb[$];

  line_mem_arbiter #(.ADDR_W(32), .LINE_W(256), .OFFSET_W(5)) dut (
    .clk(clk), .rst(rst),
    .i_addr(i_addr), .i_read(i_read), .i_rdata(i_rdata), .i_resp(i_resp),
    .d_addr(d_addr), .d_read(d_read), .d_write(d_write), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_resp(d_resp),
    .mem_addr(mem_addr), .mem_read(mem_read), .mem_write(mem_write),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_resp(mem_resp),
    .proto_err(proto_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic chkBit(input string tag, input logic obs, input logic exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s observed=%0b expected=%0b", tag, obs, exp);
    end
  endtask

  task automatic chkAddr(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s observed=%08h expected=%08h", tag, obs, exp);
    end
  endtask

  task automatic chkVec(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s observed=%064h expected=%064h", tag, obs, exp);
    end
  endtask

  function automatic logic [255:0] randLine();
    logic [255:0] v;
    for (int k = 0; k < 8; k++) v[k*32 +: 32] = $urandom();
    return v;
  endfunction

  task automatic applyStimulus(input logic iRead, input logic [31:0] iAddr,
                               input logic dRead, input logic dWrite,
                               input logic [31:0] dAddr, input logic [255:0] dWdata);
    i_read  = iRead;
    i_addr  = iAddr;
    d_read  = dRead;
    d_write = dWrite;
    d_addr  = dAddr;
    d_wdata = dWdata;
  endtask

  task automatic checkOutput();
    resp_t exp;
    chkBit("sb_has_entry", sb.size() != 0, 1'b1);
    if (sb.size() != 0) begin
      exp = sb.pop_front();
      chkBit("i_resp", i_resp, exp.owner == OWN_I);
      chkBit("d_resp", d_resp, exp.owner == OWN_D);
      chkVec("i_rdata", i_rdata, (exp.owner == OWN_I) ? exp.data : 256'd0);
      chkVec("d_rdata", d_rdata, (exp.owner == OWN_D) ? exp.data : 256'd0);
    end
  endtask

  // Memory answers in the current cycle; leaves the bench in the following (HOLD) cycle.
  task automatic respond(input logic owner);
    resp_t e;
    e.owner   = owner;
    e.data    = randLine();
    mem_rdata = e.data;
    mem_resp  = 1'b1;
    sb.push_back(e);
    #1;
    checkOutput();
    tick();
    mem_resp  = 1'b0;
    mem_rdata = '0;
  endtask

  initial begin
    logic [255:0] pat;
    logic [255:0] line;
    total = 0;
    bad   = 0;
    rst       = 1'b1;
    mem_resp  = 1'b0;
    mem_rdata = '0;
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, '0);
    tick();
    tick();
    chkBit("rst_mem_read", mem_read, 1'b0);
    chkBit("rst_mem_write", mem_write, 1'b0);
    chkAddr("rst_mem_addr", mem_addr, 32'h0);
    chkVec("rst_mem_wdata", mem_wdata, 256'd0);
    chkBit("rst_i_resp", i_resp, 1'b0);
    chkBit("rst_d_resp", d_resp, 1'b0);
    chkVec("rst_i_rdata", i_rdata, 256'd0);
    chkVec("rst_d_rdata", d_rdata, 256'd0);
    chkBit("rst_proto_err", proto_err, 1'b0);

    // Contention from reset release: D, then I, then D again.
    rst = 1'b0;
    applyStimulus(1'b1, 32'h0000_1234, 1'b1, 1'b0, 32'h8000_0040, '0);
    tick();
    chkBit("c1_read", mem_read, 1'b1);
    chkBit("c1_write", mem_write, 1'b0);
    chkAddr("c1_addr", mem_addr, 32'h8000_0040);
    tick();
    tick();
    respond(OWN_D);
    chkBit("c1_hold_read", mem_read, 1'b0);
    tick();
    chkBit("c1_idle_read", mem_read, 1'b0);
    tick();
    chkBit("c2_read", mem_read, 1'b1);
    chkAddr("c2_addr", mem_addr, 32'h0000_1220);
    tick();
    respond(OWN_I);
    tick();
    tick();
    chkBit("c3_read", mem_read, 1'b1);
    chkAddr("c3_addr", mem_addr, 32'h8000_0040);
    tick();
    respond(OWN_D);
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, '0);
    tick();

    // Single icache read, held one cycle past the response (HOLD absorption).
    applyStimulus(1'b1, 32'h0000_1234, 1'b0, 1'b0, 32'h0, '0);
    tick();
    chkBit("s_read", mem_read, 1'b1);
    chkAddr("s_addr", mem_addr, 32'h0000_1220);
    for (int k = 0; k < 3; k++) begin
      tick();
      chkBit("s_read_held", mem_read, 1'b1);
    end
    tick();
    respond(OWN_I);
    chkBit("s_read_drop", mem_read, 1'b0);
    tick();
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, '0);
    for (int k = 0; k < 3; k++) begin
      tick();
      chkBit("s_no_second", mem_read | mem_write, 1'b0);
    end

    // Dcache writeback.
    pat = {32{8'hA5}};
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b1, 32'h4000_007F, pat);
    tick();
    for (int k = 0; k < 3; k++) begin
      chkBit("wb_write", mem_write, 1'b1);
      chkBit("wb_read", mem_read, 1'b0);
      chkAddr("wb_addr", mem_addr, 32'h4000_0060);
      chkVec("wb_wdata", mem_wdata, pat);
      tick();
    end
    respond(OWN_D);
    chkBit("wb_write_drop", mem_write, 1'b0);
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, '0);
    tick();

    // Owner withdraws its request mid-transaction.
    applyStimulus(1'b1, 32'h0000_2A10, 1'b0, 1'b0, 32'h0, '0);
    tick();
    chkBit("od_read", mem_read, 1'b1);
    tick();
    applyStimulus(1'b0, 32'hFFFF_FFFF, 1'b0, 1'b0, 32'h0, '0);
    for (int k = 0; k < 2; k++) begin
      tick();
      chkBit("od_read_held", mem_read, 1'b1);
      chkAddr("od_addr_held", mem_addr, 32'h0000_2A00);
    end
    respond(OWN_I);
    tick();
    chkBit("od_no_err", proto_err, 1'b0);

    // Dcache read and write together: served as a write and flagged.
    line = randLine();
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b1, 32'h1000_0005, line);
    tick();
    chkBit("rw_write", mem_write, 1'b1);
    chkBit("rw_read", mem_read, 1'b0);
    chkAddr("rw_addr", mem_addr, 32'h1000_0000);
    chkVec("rw_wdata", mem_wdata, line);
    chkBit("rw_proto_err", proto_err, 1'b1);
    tick();
    respond(OWN_D);
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, '0);
    tick();

    // Reset mid-transaction, then a stray response.
    applyStimulus(1'b1, 32'h3000_0044, 1'b0, 1'b0, 32'h0, '0);
    tick();
    chkBit("mr_read", mem_read, 1'b1);
    rst = 1'b1;
    tick();
    chkBit("mr_read_drop", mem_read, 1'b0);
    chkBit("mr_err_clear", proto_err, 1'b0);
    rst = 1'b0;
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, '0);
    mem_rdata = randLine();
    mem_resp  = 1'b1;
    #1;
    chkBit("mr_i_resp", i_resp, 1'b0);
    chkBit("mr_d_resp", d_resp, 1'b0);
    chkVec("mr_i_rdata", i_rdata, 256'd0);
    chkVec("mr_d_rdata", d_rdata, 256'd0);
    tick();
    mem_resp  = 1'b0;
    mem_rdata = '0;
    chkBit("mr_proto_err", proto_err, 1'b1);
    chkBit("mr_idle_read", mem_read | mem_write, 1'b0);
    chkBit("sb_drained", sb.size() == 0, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
